// File: rtl/fft_frame_streamer.sv
// Strobed multi-channel mic samples -> framed AXI-Stream for the FFT core.
// Channel select or average, FWFT FIFO, tlast every FRAME_LEN beats, whole frames only.
module fft_frame_streamer #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 1,
  parameter int FRAME_LEN  = 512,
  parameter int FIFO_DEPTH = 1024,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int FILL_W    = AW + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic                     mix_mode_in,
  input  logic [CH_W-1:0]          ch_sel_in,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     sample_valid_in,
  output logic [2*DATA_W-1:0]      m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [15:0]              frame_count_out,
  output logic                     overflow_out,
  output logic [FILL_W-1:0]        fill_out,
  output logic                     dbg_state
);

  localparam int LOG_CH = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int SUM_W  = DATA_W + LOG_CH;
  localparam int IDX_W  = $clog2(FRAME_LEN);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          in_idx;
  logic                      s1_valid;
  logic [DATA_W-1:0]         s1_data;
  logic [DATA_W:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [FILL_W-1:0]         fill;
  logic [DATA_W:0]           head;
  logic                      out_valid, pop, push_ok, idx_last, wrap, capture;
  logic signed [SUM_W-1:0]   sum, avg;
  logic signed [DATA_W-1:0]  ch_v;
  logic [DATA_W-1:0]         sel_v, mixed;

  // Stage-1 mixer: full-width signed sum so averaging can never overflow.
  always_comb begin
    sum   = '0;
    ch_v  = '0;
    sel_v = sample_in[DATA_W-1:0];
    for (int k = 0; k < NUM_CH; k++) begin
      ch_v = sample_in[k*DATA_W +: DATA_W];
      sum  = sum + SUM_W'(ch_v);
      if (CH_W'(k) == ch_sel_in) sel_v = ch_v;
    end
    avg   = sum >>> LOG_CH;
    mixed = mix_mode_in ? avg[DATA_W-1:0] : sel_v;
  end

  // Output handshake: a beat transfers on a cycle where tvalid and tready are
  // both high; tvalid never waits on tready, and tdata/tlast hold until transfer.
  assign out_valid = (fill != '0);
  assign pop       = out_valid & m_axis_tready;
  assign push_ok   = s1_valid & ((fill != FILL_W'(FIFO_DEPTH)) | pop);
  assign idx_last  = (in_idx == IDX_W'(FRAME_LEN - 1));
  assign wrap      = push_ok & idx_last;
  // A strobe landing on the closing wrap must not open a frame we are leaving.
  assign capture   = sample_valid_in & (state == S_STREAM) & (state_nxt == S_STREAM);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable_in) state_nxt = S_STREAM;
      S_STREAM: if (wrap && !enable_in) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      in_idx          <= '0;
      s1_valid        <= 1'b0;
      s1_data         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      frame_count_out <= '0;
      overflow_out    <= 1'b0;
    end else begin
      state    <= state_nxt;
      s1_valid <= capture;
      if (capture) s1_data <= mixed;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_idx <= idx_last ? '0 : in_idx + 1'b1;
      end
      // Rejected pushes leave in_idx alone so frame boundaries stay aligned.
      if (s1_valid && !push_ok) overflow_out <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head[DATA_W]) frame_count_out <= frame_count_out + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Frame tag is taken from in_idx at write time, so back-to-back strobes tag correctly.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= {idx_last, s1_data};
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_valid ? {head[DATA_W-1:0], {DATA_W{1'b0}}} : '0;
  assign m_axis_tlast  = out_valid & head[DATA_W];
  assign fill_out      = fill;
  assign dbg_state     = state;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer: 2 channels, 8-beat frames, 4-deep FIFO.
// Output beats are scored against an expected queue filled at stimulus time.
module tb_fft_frame_streamer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        mix_mode_in = 1'b0;
  logic        ch_sel_in = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid_in = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [15:0] frame_count_out;
  logic        overflow_out;
  logic [2:0]  fill_out;
  logic        dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_beats = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  fft_frame_streamer #(
    .DATA_W(16), .NUM_CH(2), .FRAME_LEN(8), .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .mix_mode_in(mix_mode_in), .ch_sel_in(ch_sel_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .frame_count_out(frame_count_out),
    .overflow_out(overflow_out), .fill_out(fill_out), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] c0, input logic [15:0] c1,
                      input logic [15:0] exp, input logic last, input bit keep);
    sample_in       = {c1, c0};
    sample_valid_in = 1'b1;
    if (keep) exp_q.push_back({last, exp, 16'h0000});
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || m_axis_tvalid); i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the head of the expected queue
  always @(negedge clk_in) begin
    if (!rst_in && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      n_beats++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL beat_unexpected observed=%h expected=none", {m_axis_tlast, m_axis_tdata});
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        n_cmp++;
        assert ({m_axis_tlast, m_axis_tdata} === mon_exp) else begin
          n_err++;
          $error("FAIL beat observed=%h expected=%h", {m_axis_tlast, m_axis_tdata}, mon_exp);
        end
      end
    end
  end

  initial begin
    // Reset state
    rst_in = 1'b1;
    tick(); tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_fill", fill_out, 0);
    check("rst_count", frame_count_out, 0);
    check("rst_overflow", overflow_out, 0);
    rst_in = 1'b0;
    tick();
    check("idle_state", dbg_state, 0);

    // Two frames of 1..16 with tready high
    enable_in = 1'b1; m_axis_tready = 1'b1;
    tick();
    check("stream_state", dbg_state, 1);
    for (int i = 1; i <= 16; i++) send(16'(i), 16'h0, 16'(i), (i == 8) || (i == 16), 1'b1);
    drain();
    check("t1_count", frame_count_out, 2);
    check("t1_fill", fill_out, 0);
    check("t1_overflow", overflow_out, 0);

    // Latency: strobe at t -> tvalid at t+2
    m_axis_tready = 1'b0;
    send(16'h1234, 16'h0, 16'h1234, 1'b0, 1'b1);
    check("lat_t1_tvalid", m_axis_tvalid, 0);
    tick();
    check("lat_t2_tvalid", m_axis_tvalid, 1);
    check("lat_t2_tdata", m_axis_tdata, 32'h1234_0000);
    check("lat_t2_fill", fill_out, 1);
    tick();
    check("lat_hold_tdata", m_axis_tdata, 32'h1234_0000);
    m_axis_tready = 1'b1;
    drain();
    rst_in = 1'b1; tick(); rst_in = 1'b0; exp_q.delete();
    tick();

    // Overflow: 6 strobes into a 4-deep FIFO with tready low
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(16'(i), 16'h0, 16'(i), 1'b0, i <= 4);
    tick(); tick();
    check("ovf_fill", fill_out, 4);
    check("ovf_flag", overflow_out, 1);
    check("ovf_head", m_axis_tdata, 32'h0001_0000);
    n_beats = 0;
    m_axis_tready = 1'b1;
    drain();
    check("ovf_beats", n_beats, 4);
    check("ovf_fill_after", fill_out, 0);
    check("ovf_sticky", overflow_out, 1);
    rst_in = 1'b1; tick(); rst_in = 1'b0; exp_q.delete();
    check("ovf_cleared", overflow_out, 0);
    tick();

    // Mixing and channel select, one full frame
    mix_mode_in = 1'b1;
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    send(16'hFFFD, 16'h0002, 16'hFFFF, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1);
    mix_mode_in = 1'b0; ch_sel_in = 1'b1;
    send(16'h1111, 16'h2222, 16'h2222, 1'b0, 1'b1);
    ch_sel_in = 1'b0;
    send(16'h1111, 16'h2222, 16'h1111, 1'b0, 1'b1);
    mix_mode_in = 1'b1;
    send(16'h0003, 16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'hFFFD, 16'h0000, 16'hFFFE, 1'b0, 1'b1);
    send(16'h0004, 16'h0006, 16'h0005, 1'b1, 1'b1);
    mix_mode_in = 1'b0;
    drain();
    check("mix_count", frame_count_out, 1);

    // enable drops mid-frame: frame completes, later strobes ignored
    for (int i = 1; i <= 3; i++) send(16'(i), 16'h0, 16'(i), 1'b0, 1'b1);
    enable_in = 1'b0;
    for (int i = 4; i <= 8; i++) send(16'(i), 16'h0, 16'(i), i == 8, 1'b1);
    send(16'h0009, 16'h0, 16'h0009, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("en_drop_state", dbg_state, 0);
    send(16'h000A, 16'h0, 16'h000A, 1'b0, 1'b0);
    drain();
    check("en_drop_count", frame_count_out, 2);
    check("en_drop_fill", fill_out, 0);

    // Reset mid-frame with FIFO non-empty
    enable_in = 1'b1; m_axis_tready = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) send(16'(i), 16'h0, 16'(i), 1'b0, 1'b1);
    tick(); tick();
    check("pre_rst_fill", fill_out, 3);
    rst_in = 1'b1;
    tick();
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_fill", fill_out, 0);
    check("mid_rst_count", frame_count_out, 0);
    rst_in = 1'b0; exp_q.delete();
    tick();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(11 + i), 16'h0, 16'(11 + i), i == 7, 1'b1);
    drain();
    check("post_rst_count", frame_count_out, 1);
    check("post_rst_fill", fill_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
